// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the run sequencer and its instruction decoder:
// ALU operation encodings, ISA opcodes, run states and the strobe bundle.
package ctrl_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_XOR  = 3'd3,
    ALU_SHL  = 3'd4,
    ALU_SHR  = 3'd5,
    ALU_PASS = 3'd6,
    ALU_NOP  = 3'd7
  } op_mne_t;

  typedef enum logic [3:0] {
    OPC_ADD  = 4'd0,
    OPC_ADDI = 4'd1,
    OPC_SUB  = 4'd2,
    OPC_AND  = 4'd3,
    OPC_XOR  = 4'd4,
    OPC_SHL  = 4'd5,
    OPC_SHR  = 4'd6,
    OPC_LW   = 4'd7,
    OPC_SW   = 4'd8,
    OPC_BNZ  = 4'd9,
    OPC_BZ   = 4'd10,
    OPC_JMP  = 4'd11,
    OPC_LI   = 4'd12,
    OPC_JR   = 4'd13,
    OPC_CMP  = 4'd14,
    OPC_SYS  = 4'd15
  } opc_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_t;

  // Every datapath control strobe driven by the decoder, in one bundle.
  typedef struct packed {
    logic    branch_rel_nz;
    logic    branch_rel_z;
    logic    branch_abs;
    logic    reg_write_en;
    logic    reg_sel;
    logic    lut_in;
    logic    mem_to_reg;
    logic    alu_src;
    logic    alu_sc_in;
    logic    read_mem;
    logic    write_mem;
    op_mne_t alu_op;
  } ctrl_t;

  // SYS with fcode=1 is HALT; SYS with fcode=0 is NOP.
  function automatic logic is_halt(input logic [3:0] opcode, input logic fcode);
    return (opcode == OPC_SYS) && fcode;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode/fcode -> control strobe bundle.
// With i_en low every strobe (including alu_op) is forced to zero.
module ctrl_decode
  import ctrl_sequencer_pkg::*;
(
  input  logic       i_en,
  input  logic [3:0] i_opcode,
  input  logic       i_fcode,
  output ctrl_t      o_ctrl,
  output logic       o_halt
);

  // Table lookup; any strobe not named for an opcode stays at zero.
  always_comb begin
    o_ctrl = '0;
    o_halt = 1'b0;
    if (i_en) begin
      case (opc_t'(i_opcode))
        OPC_ADD:  begin o_ctrl.alu_op = ALU_ADD; o_ctrl.reg_write_en = 1'b1; end
        OPC_ADDI: begin
          o_ctrl.alu_op       = ALU_ADD;
          o_ctrl.reg_write_en = 1'b1;
          o_ctrl.alu_src      = 1'b1;
        end
        OPC_SUB:  begin o_ctrl.alu_op = ALU_SUB; o_ctrl.reg_write_en = 1'b1; end
        OPC_AND:  begin o_ctrl.alu_op = ALU_AND; o_ctrl.reg_write_en = 1'b1; end
        OPC_XOR:  begin o_ctrl.alu_op = ALU_XOR; o_ctrl.reg_write_en = 1'b1; end
        OPC_SHL:  begin
          o_ctrl.alu_op       = ALU_SHL;
          o_ctrl.reg_write_en = 1'b1;
          o_ctrl.alu_sc_in    = i_fcode;
        end
        OPC_SHR:  begin
          o_ctrl.alu_op       = ALU_SHR;
          o_ctrl.reg_write_en = 1'b1;
          o_ctrl.alu_sc_in    = i_fcode;
        end
        OPC_LW:   begin
          o_ctrl.read_mem     = 1'b1;
          o_ctrl.mem_to_reg   = 1'b1;
          o_ctrl.reg_write_en = 1'b1;
        end
        OPC_SW:   o_ctrl.write_mem     = 1'b1;
        OPC_BNZ:  o_ctrl.branch_rel_nz = 1'b1;
        OPC_BZ:   o_ctrl.branch_rel_z  = 1'b1;
        OPC_JMP:  o_ctrl.branch_abs    = 1'b1;
        OPC_LI:   begin o_ctrl.reg_sel = 1'b1; o_ctrl.reg_write_en = 1'b1; end
        OPC_JR:   begin o_ctrl.branch_abs = 1'b1; o_ctrl.lut_in = 1'b1; end
        // Compare only updates flags, so no register write.
        OPC_CMP:  o_ctrl.alu_op = ALU_SUB;
        OPC_SYS:  begin
          o_ctrl.alu_op = ALU_NOP;
          o_halt        = is_halt(i_opcode, i_fcode);
        end
        default:  o_ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Run-lifecycle controller for the 9-bit-ISA datapath. Holds the datapath in
// START while idle/initialising/finished, lets it run until DONE, HALT or the
// watchdog fires, and reports completion to the host via ack/timeout.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 16,
  parameter int MAX_CYCLES  = 65535
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             start_req,
  input  logic [3:0]       opcode,
  input  logic             fcode,
  input  logic             DONE,
  output logic             START,
  output logic             CTRL_branch_rel_nz,
  output logic             CTRL_branch_rel_z,
  output logic             CTRL_branch_abs,
  output logic             CTRL_reg_write_en,
  output logic             CTRL_reg_sel,
  output logic             CTRL_lut_in,
  output logic             CTRL_mem_to_reg,
  output logic             CTRL_alu_src,
  output logic             CTRL_alu_sc_in,
  output logic             CTRL_read_mem,
  output logic             CTRL_write_mem,
  output logic [2:0]       CTRL_alu_op,
  output logic             busy,
  output logic             ack,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int               INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);

  seq_state_t        r_state;
  logic [INIT_W-1:0] r_init_cnt;
  logic [CNT_W-1:0]  r_cycle_count;
  logic              r_start;
  logic              r_busy;
  logic              r_ack;
  logic              r_timeout;

  ctrl_t             w_ctrl;
  logic              w_halt;
  logic              w_run;
  logic              w_wdog;
  logic [CNT_W-1:0]  w_cnt_next;

  assign w_run  = (r_state == ST_RUN);
  assign w_wdog = (r_cycle_count == CNT_LAST);
  // Saturating increment: the counter never wraps back to zero.
  assign w_cnt_next = (r_cycle_count == CNT_MAX) ? r_cycle_count
                                                 : r_cycle_count + CNT_W'(1);

  ctrl_decode u_decode (
    .i_en     (w_run),
    .i_opcode (opcode),
    .i_fcode  (fcode),
    .o_ctrl   (w_ctrl),
    .o_halt   (w_halt)
  );

  // Run FSM with registered START/busy/ack/timeout and the RUN cycle counter.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_init_cnt    <= '0;
      r_cycle_count <= '0;
      r_start       <= 1'b1;
      r_busy        <= 1'b0;
      r_ack         <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_start <= 1'b1;
          r_ack   <= 1'b0;
          if (start_req) begin
            r_state       <= ST_INIT;
            r_init_cnt    <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        ST_INIT: begin
          if (r_init_cnt == INIT_LAST) begin
            r_state <= ST_RUN;
            r_start <= 1'b0;
          end else begin
            r_init_cnt <= r_init_cnt + INIT_W'(1);
          end
        end
        ST_RUN: begin
          r_cycle_count <= w_cnt_next;
          if (DONE || w_halt || w_wdog) begin
            r_state   <= ST_FINISH;
            r_start   <= 1'b1;
            r_busy    <= 1'b0;
            r_ack     <= 1'b1;
            // A normal end in the same cycle as the watchdog is not a timeout.
            r_timeout <= w_wdog && !DONE && !w_halt;
          end
        end
        ST_FINISH: begin
          if (!start_req) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_start <= 1'b1;
          r_busy  <= 1'b0;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign START              = r_start;
  assign busy               = r_busy;
  assign ack                = r_ack;
  assign timeout            = r_timeout;
  assign cycle_count        = r_cycle_count;

  assign CTRL_branch_rel_nz = w_ctrl.branch_rel_nz;
  assign CTRL_branch_rel_z  = w_ctrl.branch_rel_z;
  assign CTRL_branch_abs    = w_ctrl.branch_abs;
  assign CTRL_reg_write_en  = w_ctrl.reg_write_en;
  assign CTRL_reg_sel       = w_ctrl.reg_sel;
  assign CTRL_lut_in        = w_ctrl.lut_in;
  assign CTRL_mem_to_reg    = w_ctrl.mem_to_reg;
  assign CTRL_alu_src       = w_ctrl.alu_src;
  assign CTRL_alu_sc_in     = w_ctrl.alu_sc_in;
  assign CTRL_read_mem      = w_ctrl.read_mem;
  assign CTRL_write_mem     = w_ctrl.write_mem;
  assign CTRL_alu_op        = w_ctrl.alu_op;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed lifecycle steps plus randomized runs,
// checked against a decode table and a run-length model built from the
// end-of-run rules (first of DONE, HALT, watchdog).
module tb_ctrl_sequencer;

  localparam int INIT_C = 2;
  localparam int CW     = 16;
  localparam int MAXC   = 40;

  // Strobe bit positions within the 11-bit strobe field of the packed vector.
  localparam logic [10:0] S_NZ  = 11'b100_0000_0000;
  localparam logic [10:0] S_Z   = 11'b010_0000_0000;
  localparam logic [10:0] S_ABS = 11'b001_0000_0000;
  localparam logic [10:0] S_WE  = 11'b000_1000_0000;
  localparam logic [10:0] S_SEL = 11'b000_0100_0000;
  localparam logic [10:0] S_LUT = 11'b000_0010_0000;
  localparam logic [10:0] S_M2R = 11'b000_0001_0000;
  localparam logic [10:0] S_SRC = 11'b000_0000_1000;
  localparam logic [10:0] S_SC  = 11'b000_0000_0100;
  localparam logic [10:0] S_RD  = 11'b000_0000_0010;
  localparam logic [10:0] S_WR  = 11'b000_0000_0001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_req;
  logic [3:0]    opcode;
  logic          fcode;
  logic          done;
  logic          START;
  logic          b_nz, b_z, b_abs, we, rsel, lut, m2r, asrc, sc, rd, wr;
  logic [2:0]    alu_op;
  logic          busy, ack, timeout;
  logic [CW-1:0] cycle_count;
  logic [13:0]   ctrl_vec;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign ctrl_vec = {b_nz, b_z, b_abs, we, rsel, lut, m2r, asrc, sc, rd, wr, alu_op};

  ctrl_sequencer #(.INIT_CYCLES(INIT_C), .CNT_W(CW), .MAX_CYCLES(MAXC)) dut (
    .CLK                (clk),
    .reset_n            (rst_n),
    .start_req          (start_req),
    .opcode             (opcode),
    .fcode              (fcode),
    .DONE               (done),
    .START              (START),
    .CTRL_branch_rel_nz (b_nz),
    .CTRL_branch_rel_z  (b_z),
    .CTRL_branch_abs    (b_abs),
    .CTRL_reg_write_en  (we),
    .CTRL_reg_sel       (rsel),
    .CTRL_lut_in        (lut),
    .CTRL_mem_to_reg    (m2r),
    .CTRL_alu_src       (asrc),
    .CTRL_alu_sc_in     (sc),
    .CTRL_read_mem      (rd),
    .CTRL_write_mem     (wr),
    .CTRL_alu_op        (alu_op),
    .busy               (busy),
    .ack                (ack),
    .timeout            (timeout),
    .cycle_count        (cycle_count)
  );

  // Expected strobes during RUN, straight from the instruction table.
  function automatic logic [13:0] exp_ctrl(input logic [3:0] op, input logic f);
    logic [10:0] s;
    logic [2:0]  a;
    s = '0;
    a = 3'd0;
    case (op)
      4'd0:  begin a = 3'd0; s = S_WE; end
      4'd1:  begin a = 3'd0; s = S_WE | S_SRC; end
      4'd2:  begin a = 3'd1; s = S_WE; end
      4'd3:  begin a = 3'd2; s = S_WE; end
      4'd4:  begin a = 3'd3; s = S_WE; end
      4'd5:  begin a = 3'd4; s = S_WE | (f ? S_SC : 11'd0); end
      4'd6:  begin a = 3'd5; s = S_WE | (f ? S_SC : 11'd0); end
      4'd7:  s = S_RD | S_M2R | S_WE;
      4'd8:  s = S_WR;
      4'd9:  s = S_NZ;
      4'd10: s = S_Z;
      4'd11: s = S_ABS;
      4'd12: s = S_SEL | S_WE;
      4'd13: s = S_ABS | S_LUT;
      4'd14: a = 3'd1;
      default: a = 3'd7;
    endcase
    return {s, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Host-side view expected outside RUN (IDLE or FINISH).
  task automatic chk_quiet(input string tag, input logic exp_ack, input logic [CW-1:0] exp_cnt);
    chk({tag, "_start"}, 32'(START), 32'd1);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_ack"},   32'(ack),   32'(exp_ack));
    chk({tag, "_cnt"},   32'(cycle_count), 32'(exp_cnt));
    chk({tag, "_ctrl"},  32'(ctrl_vec), 32'd0);
  endtask

  // One complete run from IDLE to FINISH. Model: the run ends in the first
  // RUN cycle k that has DONE, a HALT instruction, or k == MAXC; cycle_count
  // then equals k, and timeout is set only when neither DONE nor HALT ended it.
  task automatic do_run(input string tag, input int done_at, input int halt_at,
                        input bit sweep, output int end_k, output bit tmo);
    logic [3:0] op;
    logic       f;
    bit         fin;
    bit         is_h;
    end_k = 0;
    tmo   = 1'b0;
    fin   = 1'b0;
    start_req = 1'b1;
    done      = 1'b0;
    @(negedge clk);
    for (int i = 0; i < INIT_C; i++) begin
      opcode = 4'($urandom);
      fcode  = 1'($urandom);
      start_req = 1'($urandom);
      #1;
      chk({tag, "_init_start"}, 32'(START), 32'd1);
      chk({tag, "_init_busy"},  32'(busy),  32'd1);
      chk({tag, "_init_ctrl"},  32'(ctrl_vec), 32'd0);
      @(negedge clk);
    end
    for (int k = 1; k <= MAXC && !fin; k++) begin
      if (sweep) begin
        {op, f} = 5'(k - 1);
      end else if (k == halt_at) begin
        op = 4'hF;
        f  = 1'b1;
      end else begin
        do begin
          op = 4'($urandom);
          f  = 1'($urandom);
        end while (op == 4'hF && f);
      end
      opcode    = op;
      fcode     = f;
      done      = (k == done_at);
      start_req = 1'($urandom);
      #1;
      chk({tag, "_run_start"}, 32'(START), 32'd0);
      chk({tag, "_run_busy"},  32'(busy),  32'd1);
      chk({tag, "_run_cnt"},   32'(cycle_count), 32'(k - 1));
      chk({tag, "_run_ctrl"},  32'(ctrl_vec), 32'(exp_ctrl(op, f)));
      is_h = (op == 4'hF) && f;
      if (done || is_h || k == MAXC) begin
        fin   = 1'b1;
        end_k = k;
        tmo   = !(done || is_h);
      end
      @(negedge clk);
    end
    done = 1'b0;
    #1;
    chk({tag, "_fin_ack"},     32'(ack),     32'd1);
    chk({tag, "_fin_timeout"}, 32'(timeout), 32'(tmo));
    chk_quiet({tag, "_fin"}, 1'b1, CW'(end_k));
  endtask

  // Stay in FINISH with start_req high for a while, then release to IDLE.
  task automatic release_run(input string tag, input int hold, input int end_k, input bit tmo);
    start_req = 1'b1;
    for (int i = 0; i < hold; i++) begin
      {opcode, fcode} = 5'(i);
      @(negedge clk);
      #1;
      chk_quiet({tag, "_hold"}, 1'b1, CW'(end_k));
      chk({tag, "_hold_tmo"}, 32'(timeout), 32'(tmo));
    end
    start_req = 1'b0;
    @(negedge clk);
    #1;
    chk_quiet({tag, "_idle"}, 1'b0, CW'(end_k));
  endtask

  initial begin
    int  e;
    bit  t;
    int  da, ha;
    rst_n     = 1'b0;
    start_req = 1'b0;
    opcode    = 4'd0;
    fcode     = 1'b0;
    done      = 1'b0;

    // Reset state.
    @(negedge clk);
    #1;
    chk_quiet("reset", 1'b0, '0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_quiet("idle", 1'b0, '0);

    // Decode is silent in IDLE for every opcode/fcode.
    for (int i = 0; i < 32; i++) begin
      {opcode, fcode} = 5'(i);
      #1;
      chk("idle_sweep_ctrl", 32'(ctrl_vec), 32'd0);
    end
    @(negedge clk);

    // DONE in RUN cycle 10; then linger in FINISH sweeping the decoder.
    do_run("done10", 10, 0, 1'b0, e, t);
    chk("done10_len", 32'(e), 32'd10);
    release_run("done10", 32, e, t);

    // Opcode/fcode sweep in RUN; the final combination is HALT (cycle 32).
    do_run("sweep", 0, 0, 1'b1, e, t);
    chk("sweep_len", 32'(e), 32'd32);
    release_run("sweep", 1, e, t);

    // Watchdog with no DONE, then DONE on the watchdog cycle itself.
    do_run("wdog", 0, 0, 1'b0, e, t);
    chk("wdog_tmo", 32'(t), 32'd1);
    release_run("wdog", 2, e, t);
    do_run("wdog_done", MAXC, 0, 1'b0, e, t);
    release_run("wdog_done", 0, e, t);
    do_run("wdog_halt", 0, MAXC, 1'b0, e, t);
    release_run("wdog_halt", 0, e, t);

    // HALT in RUN cycle 3.
    do_run("halt3", 0, 3, 1'b0, e, t);
    chk("halt3_len", 32'(e), 32'd3);
    release_run("halt3", 1, e, t);

    // Randomized runs; end points beyond MAXC exercise the watchdog.
    for (int r = 0; r < 8; r++) begin
      da = int'($urandom_range(1, MAXC + 8));
      ha = int'($urandom_range(1, MAXC + 8));
      do_run("rand", da, ha, 1'b0, e, t);
      release_run("rand", int'($urandom_range(0, 3)), e, t);
    end

    // Asynchronous reset in the middle of a run.
    start_req = 1'b1;
    opcode    = 4'd0;
    fcode     = 1'b0;
    repeat (INIT_C + 3) @(negedge clk);
    #1;
    chk("mid_run_busy", 32'(busy), 32'd1);
    chk("mid_run_cnt",  32'(cycle_count), 32'd2);
    chk("mid_run_ctrl", 32'(ctrl_vec), 32'(exp_ctrl(4'd0, 1'b0)));
    rst_n     = 1'b0;
    start_req = 1'b0;
    #1;
    chk_quiet("async_rst", 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_quiet("post_rst", 1'b0, '0);
    chk("post_rst_timeout", 32'(timeout), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
